d2h: RTL and testbench
======================

# d2h

Sequential BCD-to-binary converter: the inverse of the score path's binary-to-digit splitter. It takes a packed group of decimal digits, for example a high-score or seed entered digit by digit on the switches. It converts the digits most-significant first with one multiply-by-ten-and-add per clock. It returns an unsigned binary value with a start/busy/done handshake and a flag for invalid digits.

## Interface
- NUM_DIGITS, 5, number of BCD digits converted
- OUT_W, 17, result width; must be ≥ ceil(log2(10^NUM_DIGITS)); 17 covers 99999
- clk  in  1  clock, all state on rising edge
- resetN  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while idle
- bcd_in  in  4*NUM_DIGITS  packed digits; bits [4*NUM_DIGITS-1 -: 4] are the most-significant digit, bits [3:0] are the units digit
- busy  out  1  high while a conversion is in progress
- done  out  1  single-cycle pulse when result and err are valid
- value  out  OUT_W  binary result; held until the next done
- err  out  1  set with done if any digit > 9; held until the next done

## Operation
- Reset (resetN low, asynchronous): state=IDLE; busy, done, err = 0; value = 0; internal accumulator, shift register and digit counter = 0.
- States:
  - IDLE: start=1 at an edge captures bcd_in into the shift register, clears the accumulator, counter and error-sticky bit, and moves to CONV. start=0 stays in IDLE.
  - CONV: each edge does the following:
    - acc ← acc*10 + top nibble of the shift register.
    - Shift the register left by 4.
    - Counter +1.
    - If the top nibble > 9, set error-sticky.
    - When the counter reaches NUM_DIGITS-1 at this edge, the following also happen at the same edge: go to IDLE, register value, register err, and pulse done.
- acc*10 is computed as (acc<<3)+(acc<<1) in OUT_W bits. With all digits valid, no overflow is possible. With invalid digits, wrap is permitted internally.
- Result on error: value is forced to 0 and err=1. The accumulator content is discarded.
- start while busy: ignored, with no queueing. The bcd_in captured at start is used throughout, so later bcd_in changes have no effect.
- start in the cycle where done=1: state is IDLE, so it is accepted. This allows back-to-back conversions.
- value and err change only at the edge that raises done.
- Reset mid-conversion: immediate abort to reset values. No done is produced for the aborted request.

## Timing
- The start edge is E0, where start is sampled high in IDLE. The digits are processed at edges E1..E_NUM_DIGITS.
- busy is high from after E0 until after E_NUM_DIGITS, which is 5 cycles for the default.
- done is high for exactly one cycle, between E_NUM_DIGITS and E_NUM_DIGITS+1. value and err are valid from the same edge.
- Latency from start to done is NUM_DIGITS+1 clock cycles. Maximum throughput is one conversion per NUM_DIGITS+1 cycles.
- The critical path is one 4-bit add plus one OUT_W-bit shift-add.

## Structure
- The shared package holds the following:
  - The state enum {IDLE, CONV}.
  - Default constants for NUM_DIGITS and OUT_W.
  - The helper function is_bcd(nibble), which tests nibble ≤ 9.
- The counter width is $clog2(NUM_DIGITS). It is sized locally.
- One combinational sub-module is natural: d2h_mac10 (inputs acc[OUT_W], digit[4]; output acc*10+digit). It is reusable by the keypad entry logic.

## Test plan
- bcd_in=0x12345 with start pulsed for 1 cycle. Required: busy for 5 cycles, then done=1 for 1 cycle with value=12345 (0x3039) and err=0.
- bcd_in=0x99999. Required: value=99999 (0x1869F) and err=0. bcd_in=0x00000 → value=0 and err=0.
- bcd_in=0x12A45, with the invalid digit in the hundreds position. Required: done after 6 cycles with err=1 and value=0. A following conversion of 0x00042 gives value=42 and err=0.
- Start on 0x12345, then at cycle 2 change bcd_in to 0x00007 and pulse start again. Required: the second start is ignored, value=12345, and exactly one done pulse.
- Start on 0x12345, then at cycle 3 pull resetN low for 1 cycle. Required: busy=0, done never pulses, and value=0. A fresh start on 0x00100 gives value=100.
- Assert start on the done cycle of 0x00001 with bcd_in=0x00002. Required: second done exactly 6 cycles later with value=2, and the first done with value=1.

Source files
------------

// File: rtl/d2h_pkg.sv
// d2h shared definitions: state encoding, default sizes and
// the digit validity helper used by the BCD-to-binary path.
package d2h_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int NUM_DIGITS_DEF = 5;
    localparam int OUT_W_DEF      = 17;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/d2h_if.sv
// d2h request/response bundle: start + packed digits in,
// busy/done handshake with binary result and error flag out.
interface d2h_if
    import d2h_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int OUT_W      = OUT_W_DEF
);

    logic                    start;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    busy;
    logic                    done;
    logic [OUT_W-1:0]        value;
    logic                    err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  value,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output value,
        output err
    );

endinterface

// File: rtl/d2h_mac10.sv
// Combinational multiply-by-ten-and-add step: acc*10 + digit,
// built from two shifts so no multiplier is inferred.
module d2h_mac10 #(
    parameter int OUT_W = 17
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [OUT_W-1:0] result
);

    logic [OUT_W-1:0] times8;
    logic [OUT_W-1:0] times2;
    logic [OUT_W-1:0] digit_ext;

    assign times8    = acc << 3;
    assign times2    = acc << 1;
    assign digit_ext = OUT_W'(digit);

    // Wraps silently in OUT_W bits; only reachable with invalid digits.
    assign result = times8 + times2 + digit_ext;

endmodule

// File: rtl/d2h.sv
// Sequential BCD-to-binary converter: one digit per clock,
// most-significant first, with start/busy/done handshake.
module d2h
    import d2h_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int OUT_W      = OUT_W_DEF
) (
    input logic   clk,
    input logic   resetN,
    d2h_if.slave  bus
);

    localparam int SR_W = 4 * NUM_DIGITS;
    localparam int CW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    state_t           state;
    logic [SR_W-1:0]  sr;
    logic [OUT_W-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             err_s;

    logic             busy_q;
    logic             done_q;
    logic [OUT_W-1:0] value_q;
    logic             err_q;

    logic [3:0]       top;
    logic [OUT_W-1:0] acc_nxt;
    logic             err_nxt;

    assign top     = sr[SR_W-1 -: 4];
    assign err_nxt = err_s | ~is_bcd(top);

    d2h_mac10 #(
        .OUT_W (OUT_W)
    ) u_mac10 (
        .acc    (acc),
        .digit  (top),
        .result (acc_nxt)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_s   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            value_q <= '0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr     <= bus.bcd_in;
                        acc    <= '0;
                        cnt    <= '0;
                        err_s  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_nxt;
                    sr    <= sr << 4;
                    cnt   <= cnt + CW'(1);
                    err_s <= err_nxt;
                    // Last digit: result and flag land with done.
                    if (cnt == LAST) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= err_nxt;
                        value_q <= err_nxt ? '0 : acc_nxt;
                    end
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.value = value_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_d2h.sv
// Self-checking bench for d2h: vector table, random conversions
// against a decimal model, and hand-written handshake corners.
module tb_d2h;
    import d2h_pkg::*;

    localparam int ND = 5;
    localparam int OW = 17;

    logic clk;
    logic resetN;

    d2h_if #(.NUM_DIGITS(ND), .OUT_W(OW)) bus ();

    d2h #(.NUM_DIGITS(ND), .OUT_W(OW)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [19:0] bcd;
        int          exp_value;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint got,
                         input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Decimal reading of the digit string; any digit above 9 poisons it.
    function automatic void model(input logic [19:0] bcd,
                                  output int v, output logic e);
        int d;
        v = 0;
        e = 1'b0;
        for (int i = ND - 1; i >= 0; i--) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) e = 1'b1;
            v = v * 10 + d;
        end
        if (e) v = 0;
    endfunction

    // One full conversion with timing checks on busy and done.
    task automatic run(input logic [19:0] bcd, input int exp_v,
                       input logic exp_e, input string name);
        int n;
        int busy_cycles;
        @(negedge clk);
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        n = 1;
        busy_cycles = 0;
        while (!bus.done && n < 20) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            n++;
        end
        check({name, ".latency"}, n, 6);
        check({name, ".busy_cycles"}, busy_cycles, 5);
        check({name, ".value"}, bus.value, exp_v);
        check({name, ".err"}, bus.err, exp_e);
        check({name, ".busy_at_done"}, bus.busy, 0);
        @(negedge clk);
        check({name, ".done_pulse"}, bus.done, 0);
        check({name, ".value_hold"}, bus.value, exp_v);
    endtask

    initial begin
        int v;
        logic e;
        int n;
        int dones;
        logic [19:0] r;

        bus.start  = 1'b0;
        bus.bcd_in = '0;
        resetN     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        check("reset.value", bus.value, 0);
        check("reset.err", bus.err, 0);
        resetN = 1'b1;

        vecs.push_back('{20'h12345, 12345, 1'b0});
        vecs.push_back('{20'h99999, 99999, 1'b0});
        vecs.push_back('{20'h00000, 0,     1'b0});
        vecs.push_back('{20'h12A45, 0,     1'b1});
        vecs.push_back('{20'h00042, 42,    1'b0});
        vecs.push_back('{20'hF0000, 0,     1'b1});
        vecs.push_back('{20'h0000B, 0,     1'b1});
        vecs.push_back('{20'h10000, 10000, 1'b0});
        vecs.push_back('{20'h00009, 9,     1'b0});
        foreach (vecs[i])
            run(vecs[i].bcd, vecs[i].exp_value, vecs[i].exp_err,
                $sformatf("vec%0d", i));

        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < ND; j++)
                r[4*j +: 4] = ($urandom_range(0, 7) == 0)
                    ? 4'($urandom_range(10, 15))
                    : 4'($urandom_range(0, 9));
            model(r, v, e);
            run(r, v, e, $sformatf("rand%0d", k));
        end

        // Second start while busy is ignored.
        @(negedge clk);
        bus.bcd_in = 20'h12345;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.bcd_in = 20'h00007;
        @(negedge clk);
        bus.start  = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) begin
                dones++;
                check("ignore.value", bus.value, 12345);
            end
            @(negedge clk);
        end
        check("ignore.done_count", dones, 1);

        // Reset mid-conversion aborts with no done.
        @(negedge clk);
        bus.bcd_in = 20'h12345;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check("abort.busy", bus.busy, 0);
        check("abort.value", bus.value, 0);
        check("abort.err", bus.err, 0);
        @(negedge clk);
        resetN = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("abort.done_count", dones, 0);
        check("abort.value_after", bus.value, 0);
        run(20'h00100, 100, 1'b0, "after_abort");

        // Back-to-back: start accepted in the done cycle.
        @(negedge clk);
        bus.bcd_in = 20'h00001;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b.first_latency", n, 6);
        check("b2b.first_value", bus.value, 1);
        bus.bcd_in = 20'h00002;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b.second_gap", n, 6);
        check("b2b.second_value", bus.value, 2);
        check("b2b.second_err", bus.err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
